// File: rtl/i2c_master_reg_writer.sv
// I2C master that writes one register of a Game_Player slave:
// START, {SLAVE_ADDR,W}, register pointer, data byte, STOP, with an ACK check after each byte.
module i2c_master_reg_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010_101,
  parameter int         QTR_DIV    = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       SCL,
  inout  wire        SDA
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP, S_DONE
  } state_t;

  localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [QW-1:0] QTR_LAST = QW'(QTR_DIV - 1);

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          ack_error_q, ack_error_d;
  logic          scl_q, scl_d;
  logic          sda_low_q, sda_low_d;
  logic          tick;
  logic          is_ack;
  logic          sda_ack;

  // Anything other than a solid 0 on a released line is a NACK.
  assign sda_ack = (SDA == 1'b0);

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    reg_d       = reg_q;
    data_d      = data_q;
    ack_error_d = ack_error_q;
    tick        = 1'b0;
    is_ack      = (state_q == S_ACK1) || (state_q == S_ACK2) || (state_q == S_ACK3);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_START;
          reg_d       = reg_addr;
          data_d      = wdata;
          ack_error_d = 1'b0;
          qcnt_d      = '0;
          phase_d     = 2'd0;
          bit_d       = 3'd0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (qcnt_q == QTR_LAST) begin
          qcnt_d = '0;
          tick   = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
    endcase

    if (tick) begin
      phase_d = phase_q + 2'd1;
      if (is_ack && phase_q == 2'd2) begin
        if (sda_ack) ack_error_d = ack_error_q;
        else         ack_error_d = 1'b1;
      end
      // Bit/state boundaries fall on the end of ph3.
      if (phase_q == 2'd3) begin
        case (state_q)
          S_START: begin
            state_d = S_ADDR;
            shift_d = {SLAVE_ADDR, 1'b0};
            bit_d   = 3'd0;
          end
          S_ADDR, S_REG, S_DATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (state_q == S_ADDR)     state_d = S_ACK1;
              else if (state_q == S_REG) state_d = S_ACK2;
              else                       state_d = S_ACK3;
            end
          end
          S_ACK1: begin
            state_d = ack_error_q ? S_STOP : S_REG;
            shift_d = reg_q;
          end
          S_ACK2: begin
            state_d = ack_error_q ? S_STOP : S_DATA;
            shift_d = data_q;
          end
          S_ACK3:  state_d = S_STOP;
          S_STOP:  state_d = S_DONE;
          default: state_d = state_q;
        endcase
      end
    end

    // Bus pins are decoded from the next state so they come straight from flops.
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_d     = (phase_d != 2'd3);
        sda_low_d = (phase_d != 2'd0);
      end
      S_ADDR, S_REG, S_DATA: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = ~shift_d[7];
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = 1'b0;
      end
      S_STOP: begin
        scl_d     = (phase_d != 2'd0);
        sda_low_d = (phase_d != 2'd3);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      phase_q     <= 2'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      reg_q       <= 8'h00;
      data_q      <= 8'h00;
      ack_error_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      ack_error_q <= ack_error_d;
      scl_q       <= scl_d;
      sda_low_q   <= sda_low_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign ack_error = ack_error_q;
  assign SCL       = scl_q;
  assign SDA       = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_reg_writer.sv
// Bench for i2c_master_reg_writer: ACK/NACK slave model, bus decoder, done monitor and scoreboard.
module tb_i2c_master_reg_writer;

  localparam int QTR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl;
  wire        sda;
  logic       slave_low;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master_reg_writer #(.SLAVE_ADDR(7'b1010_101), .QTR_DIV(QTR)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_error(ack_error), .SCL(scl), .SDA(sda)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  // Scoreboard state
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [0:0] exp_err_q[$];
  int         exp_lat_q[$];
  int         exp_rise_q[$];
  int nack_idx = 3;
  int viol     = 0;
  int done_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an output with nothing expected", name);
  endfunction

  // Model of one request: nack 0..2 = byte that gets NACKed, 3 = all ACKed.
  task automatic push_frame(input logic [7:0] ra, input logic [7:0] wd, input int nack);
    int n;
    n = (nack > 2) ? 3 : nack + 1;
    exp_q.push_back(8'hAA);
    if (n > 1) exp_q.push_back(ra);
    if (n > 2) exp_q.push_back(wd);
    exp_err_q.push_back(1'(nack <= 2));
    exp_lat_q.push_back((8 + 36 * n) * QTR);
    exp_rise_q.push_back(9 * n + 1);
  endtask

  // Driver tasks
  task automatic issue(input logic [7:0] ra, input logic [7:0] wd);
    @(posedge clk);
    @(negedge clk);
    reg_addr = ra;
    wdata    = wd;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ack_error_cleared", ack_error, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  // Slave model: ACKs every byte except byte number nack_idx of the frame.
  int   s_cnt = 0;
  int   s_idx = 0;
  logic s_pscl = 1'b1;
  logic s_psda = 1'b1;
  initial begin
    slave_low = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        slave_low = 1'b0;
        s_cnt     = 0;
      end else if (s_pscl && scl && s_psda && sda == 1'b0) begin
        s_cnt = 0;
        s_idx = 0;
      end else if (!s_pscl && scl) begin
        s_cnt++;
      end else if (s_pscl && !scl) begin
        if (s_cnt == 8) begin
          slave_low = (s_idx != nack_idx);
        end else if (s_cnt == 9) begin
          slave_low = 1'b0;
          s_cnt     = 0;
          s_idx++;
        end
      end
      s_pscl = scl;
      s_psda = sda;
    end
  end

  // Bus monitor: decodes START/STOP and bytes, checks protocol and SCL pulse count.
  logic       m_pscl = 1'b1;
  logic       m_psda = 1'b1;
  logic [7:0] m_byte = 8'h00;
  int         m_bits = 0;
  int         m_rises = 0;
  int         m_last_stop = -1;
  bit         in_frame = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
        m_bits   = 0;
      end else if (m_pscl && scl && m_psda && !sda) begin
        if (in_frame) viol++;
        if (m_last_stop >= 0) check("bus_free", 32'(cyc - m_last_stop >= 2 * QTR), 1);
        in_frame = 1'b1;
        m_bits   = 0;
        m_rises  = 0;
      end else if (m_pscl && scl && !m_psda && sda) begin
        if (!in_frame || m_bits != 1) viol++;
        in_frame    = 1'b0;
        m_bits      = 0;
        m_last_stop = cyc;
        if (exp_rise_q.size() == 0) unexpected("scl_rises");
        else check("scl_rises", m_rises, exp_rise_q.pop_front());
      end else if (!m_pscl && scl && in_frame) begin
        m_rises++;
        m_bits++;
        if (m_bits <= 8) m_byte = {m_byte[6:0], sda};
        if (m_bits == 9) begin
          m_bits = 0;
          if (exp_q.size() == 0) unexpected("bus_byte");
          else check("bus_byte", m_byte, exp_q.pop_front());
        end
      end
      m_pscl = scl;
      m_psda = sda;
    end
  end

  // Done monitor: ack_error, busy and latency from busy rising to done.
  int   d_cnt = 0;
  logic d_pbusy = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        d_cnt   = 0;
        d_pbusy = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          check("busy_low_at_done", busy, 0);
          if (exp_err_q.size() == 0) unexpected("done_pulse");
          else begin
            check("ack_error_at_done", ack_error, exp_err_q.pop_front());
            check("latency", d_cnt, exp_lat_q.pop_front());
          end
        end
        if (busy) d_cnt = d_pbusy ? d_cnt + 1 : 1;
        d_pbusy = busy;
      end
    end
  end

  logic [7:0] t6_data [3] = '{8'h11, 8'hC3, 8'h7E};

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    reg_addr = 8'h00;
    wdata    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_error", ack_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // T1: plain write
    nack_idx = 3;
    push_frame(8'h01, 8'hA5, 3);
    issue(8'h01, 8'hA5);
    wait_done();

    // T2: NACK on address byte, ack_error held afterwards
    nack_idx = 0;
    push_frame(8'h02, 8'h3C, 0);
    issue(8'h02, 8'h3C);
    wait_done();
    repeat (5) @(negedge clk);
    check("ack_error_held", ack_error, 1);

    // T3: NACK on data byte
    nack_idx = 2;
    push_frame(8'h00, 8'h5A, 2);
    issue(8'h00, 8'h5A);
    wait_done();

    // T4: second start while busy is ignored
    nack_idx = 3;
    push_frame(8'h02, 8'h81, 3);
    issue(8'h02, 8'h81);
    repeat (9) @(negedge clk);
    reg_addr = 8'h00;
    wdata    = 8'hFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check("t4_no_second_frame", busy, 0);

    // T5: reset in the middle of the register byte (bit 3, SCL low)
    exp_q.push_back(8'hAA);
    issue(8'h01, 8'h77);
    repeat (104) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_frame(8'h02, 8'h42, 3);
    issue(8'h02, 8'h42);
    wait_done();

    // T6: Reg0..Reg2 back to back, each start on the first IDLE cycle
    for (int r = 0; r < 3; r++) begin
      push_frame(8'(r), t6_data[r], 3);
      issue(8'(r), t6_data[r]);
      wait_done();
    end

    repeat (20) @(negedge clk);
    check("bytes_left", exp_q.size(), 0);
    check("dones_left", exp_err_q.size(), 0);
    check("stops_left", exp_rise_q.size(), 0);
    check("protocol_violations", viol, 0);
    check("done_pulses", done_cnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
